// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
package ps2_pkg;

    // Transmitter sequencing states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQ       = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5,
        DONE      = 3'd6,
        ERR       = 3'd7
    } tx_state_e;

    // Error codes reported on tx_err, held until the next accepted request.
    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_START = 2'd1,
        ERR_XFER  = 2'd2,
        ERR_NOACK = 2'd3
    } tx_err_e;

    // Frame shape counted in device clock falls: data bits on falls 1..8,
    // parity on fall 9, stop (line released) on fall 10, ACK sampled on fall 11.
    localparam int FRAME_CLOCKS = 11;
    localparam int PARITY_IDX   = 9;
    localparam int STOP_IDX     = 10;

    // Default timing at a 50 MHz system clock.
    localparam int DEF_INHIBIT_CYCLES = 5000;
    localparam int DEF_START_TIMEOUT  = 750000;
    localparam int DEF_XFER_TIMEOUT   = 100000;
    localparam int DEF_FILTER_LEN     = 8;

    // PS/2 uses odd parity: data plus parity always holds an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// Pad input conditioning: two-flop synchronizer, run-length glitch filter and
// a registered one-cycle pulse on each filtered 1->0 transition.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clock50,
    input  logic reset_n,
    input  logic line_i,
    output logic level_o,
    output logic fall_o
);

    localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: shift the synchronizer, count disagreeing samples, adopt the
    // new level once FILTER_LEN of them have arrived back to back.
    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned
        // (an unassigned path in always_comb would infer a latch).
        sync1_d = line_i;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        fall_d = level_q & ~level_d;
    end

    // State registers; the idle PS/2 bus is high, so the line path resets high.
    always_ff @(posedge clock50) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // flop samples the pre-edge value of every other flop.
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            cnt_q   <= '0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// shifts one byte plus odd parity out on device clock falls, checks the ACK
// and reports busy/done/error status.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int START_TIMEOUT  = DEF_START_TIMEOUT,
    parameter int XFER_TIMEOUT   = DEF_XFER_TIMEOUT,
    parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
    input  logic       clock50,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic [1:0] tx_err,
    output logic       rx_inhibit,
    input  logic       ps2_clk_i,
    output logic       ps2_clk_oe,
    input  logic       ps2_dat_i,
    output logic       ps2_dat_oe
);

    // One shared timer serves the inhibit, start and transfer phases.
    localparam int TIMER_MAX_A = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
    localparam int TIMER_MAX   = (TIMER_MAX_A > INHIBIT_CYCLES) ? TIMER_MAX_A : INHIBIT_CYCLES;
    localparam int TIMER_W     = $clog2(TIMER_MAX + 1);

    localparam logic [TIMER_W-1:0] INHIBIT_LAST = TIMER_W'(INHIBIT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] INHIBIT_PRE  = TIMER_W'(INHIBIT_CYCLES - 2);
    localparam logic [TIMER_W-1:0] START_LAST   = TIMER_W'(START_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] XFER_LAST    = TIMER_W'(XFER_TIMEOUT - 1);

    logic clk_lvl, clk_fall;
    logic dat_lvl, dat_fall_unused;

    tx_state_e          state_q, state_d;
    logic [8:0]         bits_q, bits_d;      // {parity, data}
    logic [3:0]         bit_idx_q, bit_idx_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               clk_oe_q, clk_oe_d;
    logic               dat_oe_q, dat_oe_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    tx_err_e            err_q, err_d;
    logic [3:0]         fall_num;            // number of the fall being handled
    logic               xfer_phase;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clock50 (clock50),
        .reset_n (reset_n),
        .line_i  (ps2_clk_i),
        .level_o (clk_lvl),
        .fall_o  (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(1)) u_dat_filter (
        .clock50 (clock50),
        .reset_n (reset_n),
        .line_i  (ps2_dat_i),
        .level_o (dat_lvl),
        .fall_o  (dat_fall_unused)
    );

    // Transmit sequencer next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        bits_d     = bits_q;
        bit_idx_d  = bit_idx_q;
        timer_d    = (timer_q == '1) ? timer_q : timer_q + 1'b1;
        clk_oe_d   = clk_oe_q;
        dat_oe_d   = dat_oe_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;
        fall_num   = bit_idx_q + 4'd2;
        xfer_phase = (state_q == SEND) || (state_q == ACK) || (state_q == WAIT_IDLE);

        unique case (state_q)
            IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (tx_start) begin
                    bits_d   = {odd_parity(tx_data), tx_data};
                    busy_d   = 1'b1;
                    err_d    = ERR_NONE;
                    timer_d  = '0;
                    clk_oe_d = 1'b1;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (timer_q == INHIBIT_LAST) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b1;
                    timer_d  = '0;
                    state_d  = REQ;
                end else if (timer_q == INHIBIT_PRE) begin
                    // Data goes low one cycle before the clock is released.
                    dat_oe_d = 1'b1;
                end
            end
            REQ: begin
                if (clk_fall) begin
                    bit_idx_d = '0;
                    dat_oe_d  = ~bits_q[0];
                    timer_d   = '0;
                    state_d   = SEND;
                end else if (timer_q == START_LAST) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    busy_d   = 1'b0;
                    err_d    = ERR_START;
                    state_d  = ERR;
                end
            end
            SEND: begin
                if (clk_fall) begin
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (fall_num == 4'(STOP_IDX)) begin
                        dat_oe_d = 1'b0;
                        state_d  = ACK;
                    end else if (fall_num <= 4'(PARITY_IDX)) begin
                        dat_oe_d = ~bits_q[fall_num - 4'd1];
                    end
                end
            end
            ACK: begin
                if (clk_fall && (fall_num == 4'(FRAME_CLOCKS))) begin
                    if (!dat_lvl) begin
                        state_d = WAIT_IDLE;
                    end else begin
                        busy_d  = 1'b0;
                        err_d   = ERR_NOACK;
                        state_d = ERR;
                    end
                end
            end
            WAIT_IDLE: begin
                if (clk_lvl && dat_lvl) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The transfer watchdog runs from the first fall to bus idle and
        // overrides whatever the phase logic decided this cycle.
        if (xfer_phase && (timer_q == XFER_LAST)) begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b0;
            err_d    = ERR_XFER;
            state_d  = ERR;
        end
    end

    // Sequencer state and registered outputs; reset releases both lines.
    always_ff @(posedge clock50) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            bits_q    <= '0;
            bit_idx_q <= '0;
            timer_q   <= '0;
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= ERR_NONE;
        end else begin
            state_q   <= state_d;
            bits_q    <= bits_d;
            bit_idx_q <= bit_idx_d;
            timer_q   <= timer_d;
            clk_oe_q  <= clk_oe_d;
            dat_oe_q  <= dat_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign tx_busy    = busy_q;
    assign rx_inhibit = busy_q;
    assign tx_done    = done_q;
    assign tx_err     = err_q;
    assign ps2_clk_oe = clk_oe_q;
    assign ps2_dat_oe = dat_oe_q;

endmodule
